da_lut_loader: RTL
==================

// Module: da_lut_loader
// PURPOSE
//  Writer for a distributed-arithmetic (DA) partial-sum table. From N unsigned coefficients it computes all
//  2^N table entries, entry[a] = sum of c_k over every bit k set in a. It streams them to a RAM port with a
//  write/ready handshake. A DA inner-product unit can then read coefficients from a reloadable RAM instead
//  of a fixed ROM file. The block sits between the coefficient-config path and the DA table RAM write port.
// PARAMETERS
//  N     3  number of taps = table address width; table depth 2^N
//  W_C   2  width of each unsigned coefficient
//  W_L   3  table data width; sums are truncated to W_L LSBs
// PORTS
//  clk      in   1        system clock, all logic on rising edge
//  reset    in   1        asynchronous, active-low reset (0 = reset)
//  start    in   1        request a table build; sampled only in IDLE
//  c_in     in   N*W_C    coefficients; c_k = c_in[k*W_C +: W_C]; latched when start is accepted
//  wr_rdy   in   1        table RAM accepts a write this cycle
//  we       out  1        write valid
//  addr     out  N        table write address
//  data     out  W_L      table entry for addr
//  busy     out  1        high from start acceptance until done
//  done     out  1        one-cycle pulse after the last accepted write
//  ovf      out  1        sticky: some entry exceeded W_L bits; cleared on start acceptance
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; we, addr, data, busy, done, ovf and coefficient regs all 0.
//  - FSM states and transitions:
//    IDLE -> FILL: on start=1. Latch c_in, addr<=0, busy<=1, ovf<=0.
//    FILL: we=1, data=entry(addr) is registered. A write is accepted when we && wr_rdy.
//      On acceptance with addr != 2^N-1: addr<=addr+1.
//      On acceptance with addr == 2^N-1: we<=0, go to DONE.
//    DONE: done=1 for exactly one cycle, busy<=0, -> IDLE.
//  - Timing: the first we is asserted the cycle after start is sampled. With wr_rdy held at 1, the build
//    takes 2^N write cycles plus 1 cycle for done, i.e. done rises 2^N+1 cycles after start is sampled.
//  - Handshake: while we=1 and wr_rdy=0, addr and data are held stable. Exactly one write per address,
//    in ascending order. No address is skipped or repeated.
//  - Arithmetic: unsigned sum over N terms, full width W_C+clog2(N). data = sum[W_L-1:0].
//    If any discarded upper bit is 1, ovf<=1 at acceptance of that entry.
//  - start while busy (FILL/DONE) is ignored. c_in changes after acceptance have no effect.
//    start in the DONE cycle is ignored. A new start is honoured in IDLE on the following cycle.
//  - N=1 edge case: 2 entries (0, c_0).
//  - Reset mid-build: immediate abort; we drops asynchronously; no done pulse. The table contents are
//    then undefined, and the consumer must not use them until the next done.
//  - wr_rdy is ignored whenever we=0.
// STRUCTURE
//  - Shared include da_pkg.vh: FSM state encodings (S_IDLE, S_FILL, S_DONE) and a clog2 constant function.
//    The DA reader units use the same include for matching widths.
//  - One sub-module: da_lut_sum. It is combinational: masked sum of N coefficients selected by the address
//    bits, giving the full-width sum. The parent registers and truncates it.
//  - The top level holds the FSM, address counter, coefficient register and overflow flag.
// TESTING  (defaults N=3, W_C=2, W_L=3 unless noted; c0=2, c1=3, c2=1 -> c_in=6'b01_11_10)
//  1 Basic build: wr_rdy=1, pulse start.
//    -> writes addr 0..7 = 0,2,3,5,1,3,4,6 on consecutive cycles; done 9 cycles after start; ovf=0.
//  2 Backpressure: wr_rdy=0 for 3 cycles at addr 3, and for 1 cycle at addr 7.
//    -> addr/data held (3/5, then 7/6); 8 writes total; done 1 cycle after the addr-7 acceptance.
//  3 Overflow: c0=c1=c2=3.
//    -> addr7 sum 9 gives data=1 and ovf=1 (held after done); addr3 gives data=6.
//    -> next start with c=2,3,1 clears ovf.
//  4 Start while busy: second start at addr 4 with different c_in.
//    -> ignored; table identical to scenario 1; a single done pulse.
//  5 Reset mid-build: assert reset at addr 5.
//    -> we, busy, addr, ovf = 0 immediately; no done. A fresh start yields the full scenario-1 table.
//  6 Sweep: N=4, W_C=4, W_L=6 with random c_in; wr_rdy random.
//    -> every entry matches the reference masked sum; ovf is never set.

Source files
------------

// File: rtl/da_lut_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : da_lut_loader_pkg
//  Description : Shared FSM encodings and width helper for the DA table
//                loader and the DA reader units.
//  Revision    : 1.0  initial release
// ============================================================================
package da_lut_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Ceiling log2 for constant width calculations; clog2(1) = 0.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/da_lut_sum.sv
`default_nettype none
// ============================================================================
//  Module      : da_lut_sum
//  Description : Combinational masked sum of N unsigned coefficients; a
//                coefficient contributes when its address bit is set.
//  Revision    : 1.0  initial release
// ============================================================================
module da_lut_sum #(
  parameter int N   = 3,
  parameter int W_C = 2,
  parameter int W_S = 4
) (
  input  logic [N*W_C-1:0] coef,
  input  logic [N-1:0]     sel,
  output logic [W_S-1:0]   sum
);

  // Accumulate every coefficient whose select bit is set, at full width.
  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++) begin
      if (sel[k]) begin
        sum = sum + W_S'(coef[k*W_C +: W_C]);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/da_lut_loader.sv
`default_nettype none
// ============================================================================
//  Module      : da_lut_loader
//  Description : Builds the 2^N-entry DA partial-sum table from N latched
//                coefficients and streams it to a RAM write port with a
//                we/wr_rdy handshake. Sticky ovf flags truncated entries.
//  Revision    : 1.0  initial release
// ============================================================================
module da_lut_loader
  import da_lut_loader_pkg::*;
#(
  parameter int N   = 3,
  parameter int W_C = 2,
  parameter int W_L = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N*W_C-1:0] c_in,
  input  logic             wr_rdy,
  output logic             we,
  output logic [N-1:0]     addr,
  output logic [W_L-1:0]   data,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int             W_S       = W_C + clog2(N);
  localparam logic [N-1:0]   ADDR_LAST = '1;

  state_t             state;
  state_t             state_nxt;
  logic [N*W_C-1:0]   coef;
  logic [N-1:0]       addr_nxt;
  logic [W_S-1:0]     sum_nxt;
  logic [W_L-1:0]     data_nxt;
  logic               hi_nxt;
  logic               data_hi;    // upper bits lost when data was truncated
  logic               start_ok;
  logic               accept;
  logic               last;

  assign addr_nxt = addr + N'(1);

  // The entry for the next address is precomputed so data is already
  // registered when the address advances.
  da_lut_sum #(
    .N   (N),
    .W_C (W_C),
    .W_S (W_S)
  ) u_sum (
    .coef (coef),
    .sel  (addr_nxt),
    .sum  (sum_nxt)
  );

  generate
    if (W_S > W_L) begin : g_trunc
      assign data_nxt = sum_nxt[W_L-1:0];
      assign hi_nxt   = |sum_nxt[W_S-1:W_L];
    end else begin : g_ext
      assign data_nxt = W_L'(sum_nxt);
      assign hi_nxt   = 1'b0;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and handshake qualifiers.
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        accept = we && wr_rdy;
        last   = accept && (addr == ADDR_LAST);
        if (last) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: coefficient latch, address/data stream, status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coef    <= '0;
      addr    <= '0;
      data    <= '0;
      data_hi <= 1'b0;
      we      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        // Entry 0 is the empty sum, so no adder result is needed here.
        coef    <= c_in;
        addr    <= '0;
        data    <= '0;
        data_hi <= 1'b0;
        we      <= 1'b1;
        busy    <= 1'b1;
        ovf     <= 1'b0;
      end
      if (accept) begin
        ovf <= ovf | data_hi;
        if (last) begin
          we <= 1'b0;
        end else begin
          addr    <= addr_nxt;
          data    <= data_nxt;
          data_hi <= hi_nxt;
        end
      end
      if (state == S_DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
